// File: rtl/thermocouple_scanner_if.sv
`default_nettype none
// ============================================================================
// Module : thermocouple_scanner_if
// Brief  : SPI-master handshake, scan control and result stream of the scanner.
// Rev    : 1.0  initial release
// ============================================================================
interface thermocouple_scanner_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              scan_en;
  logic              spi_busy;
  logic              spi_done;
  logic [31:0]       spi_rx_data;
  logic              spi_start;
  logic [CH_W-1:0]   spi_ch;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [13:0]       tc_temp;
  logic [11:0]       junction_temp;
  logic [3:0]        fault_bits;
  logic              out_timeout;
  logic [NUM_CH-1:0] fault_mask;
  logic              overrun;

  // master: the scanner; slave: SPI master plus downstream monitor
  modport master (
    input  scan_en, spi_busy, spi_done, spi_rx_data,
    output spi_start, spi_ch, out_valid, out_ch, tc_temp, junction_temp,
           fault_bits, out_timeout, fault_mask, overrun
  );

  modport slave (
    output scan_en, spi_busy, spi_done, spi_rx_data,
    input  spi_start, spi_ch, out_valid, out_ch, tc_temp, junction_temp,
           fault_bits, out_timeout, fault_mask, overrun
  );
endinterface
`default_nettype wire

// File: rtl/thermocouple_scanner.sv
`default_nettype none
// ============================================================================
// Module : thermocouple_scanner
// Brief  : Periodically reads NUM_CH MAX31855-style frames through an external
//          SPI master and publishes one decoded result per channel.
// Rev    : 1.0  initial release
// ============================================================================
module thermocouple_scanner #(
  parameter int NUM_CH         = 4,
  parameter int STARTUP_CYCLES = 3000,
  parameter int PERIOD_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  thermocouple_scanner_if.master bus
);

  localparam int c_su_w  = $clog2(STARTUP_CYCLES + 1);
  localparam int c_per_w = $clog2(PERIOD_CYCLES + 1);
  localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);

  // STARTUP leaves early because the IDLE and REQ cycles complete the delay:
  // the first spi_start then lands exactly on cycle STARTUP_CYCLES.
  localparam logic [c_su_w-1:0]  c_su_last  = c_su_w'((STARTUP_CYCLES > 3) ? STARTUP_CYCLES - 3 : 0);
  localparam logic [c_per_w-1:0] c_per_full = c_per_w'(PERIOD_CYCLES);
  localparam logic [c_per_w-1:0] c_per_due  = c_per_w'((PERIOD_CYCLES > 1) ? PERIOD_CYCLES - 1 : 0);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CH_W-1:0]    c_ch_last  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_REQ     = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_round_start;
  logic                w_issue;
  logic                w_done_hit;
  logic                w_to_hit;
  logic                w_result;
  logic                w_expired;
  logic                w_faulted;
  logic                w_unused_bits;

  logic [c_su_w-1:0]   r_su_cnt;
  logic [c_per_w-1:0]  r_per_cnt;
  logic [c_to_w-1:0]   r_to_cnt;
  logic [CH_W-1:0]     r_ch;
  logic                r_spi_start;
  logic                r_out_valid;
  logic [CH_W-1:0]     r_out_ch;
  logic [13:0]         r_tc_temp;
  logic [11:0]         r_junction_temp;
  logic [3:0]          r_fault_bits;
  logic                r_out_timeout;
  logic [NUM_CH-1:0]   r_fault_mask;
  logic                r_overrun;

  // Compared one cycle early so consecutive round starts are PERIOD_CYCLES apart.
  assign w_expired = (r_per_cnt >= c_per_due);
  assign w_result  = w_done_hit | w_to_hit;
  // Any raised fault flag, or a missing frame, marks the channel as faulted.
  assign w_faulted = w_to_hit |
                     (|{bus.spi_rx_data[16], bus.spi_rx_data[2:0]});
  assign w_unused_bits = ^{bus.spi_rx_data[17], bus.spi_rx_data[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STARTUP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_round_start = 1'b0;
    w_issue       = 1'b0;
    w_done_hit    = 1'b0;
    w_to_hit      = 1'b0;
    case (r_state)
      ST_STARTUP: begin
        if (r_su_cnt == c_su_last) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.scan_en && w_expired) begin
          w_round_start = 1'b1;
          w_state_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!bus.spi_busy) begin
          w_issue      = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A frame arriving on the expiry cycle still wins over the timeout.
        if (bus.spi_done) begin
          w_done_hit = 1'b1;
        end else if (r_to_cnt == c_to_last) begin
          w_to_hit = 1'b1;
        end
        if (bus.spi_done || (r_to_cnt == c_to_last)) begin
          w_state_next = (r_ch == c_ch_last) ? ST_IDLE : ST_REQ;
        end
      end
      default: begin
        w_state_next = ST_STARTUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_su_cnt        <= '0;
      r_per_cnt       <= '0;
      r_to_cnt        <= '0;
      r_ch            <= '0;
      r_spi_start     <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_ch        <= '0;
      r_tc_temp       <= '0;
      r_junction_temp <= '0;
      r_fault_bits    <= '0;
      r_out_timeout   <= 1'b0;
      r_fault_mask    <= '0;
      r_overrun       <= 1'b0;
    end else begin
      r_spi_start <= w_issue;
      r_out_valid <= w_result;

      if (r_state == ST_STARTUP) begin
        r_su_cnt <= r_su_cnt + c_su_w'(1);
      end

      if (r_state == ST_STARTUP) begin
        r_per_cnt <= c_per_full;
      end else if (w_round_start) begin
        r_per_cnt <= '0;
      end else if (r_per_cnt != c_per_full) begin
        r_per_cnt <= r_per_cnt + c_per_w'(1);
      end

      if (w_issue) begin
        r_to_cnt <= '0;
      end else if ((r_state == ST_WAIT) && (r_to_cnt != c_to_last)) begin
        r_to_cnt <= r_to_cnt + c_to_w'(1);
      end

      if (w_round_start) begin
        r_ch <= '0;
      end else if (w_result && (r_ch != c_ch_last)) begin
        r_ch <= r_ch + CH_W'(1);
      end

      if (w_result) begin
        r_out_ch      <= r_ch;
        r_out_timeout <= w_to_hit;
        if (w_done_hit) begin
          r_tc_temp       <= bus.spi_rx_data[31:18];
          r_junction_temp <= bus.spi_rx_data[15:4];
          r_fault_bits    <= {bus.spi_rx_data[16], bus.spi_rx_data[2:0]};
        end else begin
          r_tc_temp       <= '0;
          r_junction_temp <= '0;
          r_fault_bits    <= 4'b1000;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_ch == CH_W'(i)) begin
            r_fault_mask[i] <= w_faulted;
          end
        end
        if ((r_ch == c_ch_last) && w_expired) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign bus.spi_start     = r_spi_start;
  assign bus.spi_ch        = r_ch;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_ch        = r_out_ch;
  assign bus.tc_temp       = r_tc_temp;
  assign bus.junction_temp = r_junction_temp;
  assign bus.fault_bits    = r_fault_bits;
  assign bus.out_timeout   = r_out_timeout;
  assign bus.fault_mask    = r_fault_mask;
  assign bus.overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_thermocouple_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_thermocouple_scanner
// Brief  : Scoreboard bench for thermocouple_scanner with a reactive SPI slave.
// Rev    : 1.0  initial release
// ============================================================================
module tb_thermocouple_scanner;
  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  thermocouple_scanner_if #(.NUM_CH(NUM_CH)) bus ();

  thermocouple_scanner #(
    .NUM_CH(NUM_CH), .STARTUP_CYCLES(3000), .PERIOD_CYCLES(1000), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [13:0] tc;
    logic [11:0] jt;
    logic [3:0]  fb;
    logic        to;
    logic        fm;
  } exp_t;

  exp_t        exp_q[$];
  bit          resp_en;
  bit          drop_ch [NUM_CH];
  logic [31:0] rx_word [NUM_CH];
  logic [13:0] exp_tc  [NUM_CH];
  logic [11:0] exp_jt  [NUM_CH];
  logic [3:0]  exp_fb  [NUM_CH];
  bit          exp_fm  [NUM_CH];

  function automatic exp_t mk(int ch, logic [13:0] tc, logic [11:0] jt,
                              logic [3:0] fb, logic to, logic fm);
    exp_t e;
    e.ch = 2'(ch); e.tc = tc; e.jt = jt; e.fb = fb; e.to = to; e.fm = fm;
    return e;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.spi_start, bus.spi_ch, bus.out_valid, bus.out_ch, bus.tc_temp,
                bus.junction_temp, bus.fault_bits, bus.out_timeout, bus.fault_mask,
                bus.overrun});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
    finish_sim();
  endtask

  task automatic wait_start(input int bound, input string name, output int c);
    c = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.spi_start === 1'b1) begin
        c = cyc;
        return;
      end
    end
    abort(name);
  endtask

  task automatic wait_valid(input int bound, input string name, output int c);
    c = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        c = cyc;
        return;
      end
    end
    abort(name);
  endtask

  // SPI slave: answers 5 cycles after each start, or stays silent for dropped channels.
  initial begin : responder
    int ch;
    int lat;
    forever begin
      @(negedge clk);
      if (resp_en && bus.spi_start === 1'b1) begin
        ch = int'(bus.spi_ch);
        if (drop_ch[ch]) begin
          exp_q.push_back(mk(ch, 14'h0, 12'h0, 4'b1000, 1'b1, 1'b1));
          lat = 0;
          while (lat < 100 && bus.out_valid !== 1'b1) begin
            @(negedge clk);
            lat++;
          end
          check("timeout_latency", 64'(lat), 64'd64);
        end else begin
          repeat (5) @(negedge clk);
          bus.spi_rx_data = rx_word[ch];
          bus.spi_done    = 1'b1;
          exp_q.push_back(mk(ch, exp_tc[ch], exp_jt[ch], exp_fb[ch], 1'b0, exp_fm[ch]));
          @(negedge clk);
          bus.spi_done    = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: out_valid on ch %0d, expected none", bus.out_ch);
        end else begin
          e = exp_q.pop_front();
          a = mk(int'(bus.out_ch), bus.tc_temp, bus.junction_temp, bus.fault_bits,
                 bus.out_timeout, bus.fault_mask[e.ch]);
          check("result", 64'(a), 64'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    abort("global_watchdog");
  end

  initial begin : stim
    int c0, c, v, prev0, n;
    bus.scan_en = 1'b1;
    bus.spi_busy = 1'b0;
    bus.spi_done = 1'b0;
    bus.spi_rx_data = '0;
    resp_en = 1'b1;
    for (int i = 0; i < NUM_CH; i++) drop_ch[i] = 1'b0;
    rx_word[0] = 32'hAAAA_5557; exp_tc[0] = 14'h2AAA; exp_jt[0] = 12'h555; exp_fb[0] = 4'b0111; exp_fm[0] = 1'b1;
    rx_word[1] = 32'h1234_5670; exp_tc[1] = 14'h048D; exp_jt[1] = 12'h567; exp_fb[1] = 4'b0000; exp_fm[1] = 1'b0;
    rx_word[2] = 32'h0001_0000; exp_tc[2] = 14'h0000; exp_jt[2] = 12'h000; exp_fb[2] = 4'b1000; exp_fm[2] = 1'b1;
    rx_word[3] = 32'hFFFC_FFF8; exp_tc[3] = 14'h3FFF; exp_jt[3] = 12'hFFF; exp_fb[3] = 4'b0000; exp_fm[3] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    c0 = cyc;

    // Round 1: startup delay, decode, ordering and minimum inter-channel gap
    wait_start(3100, "startup", c);
    check("startup_cycle", 64'(c - c0), 64'd3000);
    check("startup_spi_ch", 64'(bus.spi_ch), 64'd0);
    prev0 = c;
    wait_valid(20, "r1_ch0_result", v);
    wait_start(20, "r1_ch1_start", c);
    check("result_to_start_gap", 64'(c - v), 64'd1);
    check("r1_ch1_spi_ch", 64'(bus.spi_ch), 64'd1);
    repeat (3) wait_valid(20, "r1_result", v);
    check("r1_fault_mask", 64'(bus.fault_mask), 64'b0101);
    check("r1_overrun", 64'(bus.overrun), 64'd0);

    // Round 2: clean frame on ch0, ch2 never answers
    rx_word[0] = 32'h1234_5670; exp_tc[0] = 14'h048D; exp_jt[0] = 12'h567; exp_fb[0] = 4'b0000; exp_fm[0] = 1'b0;
    drop_ch[2] = 1'b1;
    wait_start(1100, "r2_start", c);
    check("round_period_1", 64'(c - prev0), 64'd1000);
    check("r2_spi_ch", 64'(bus.spi_ch), 64'd0);
    prev0 = c;
    repeat (4) wait_valid(200, "r2_result", v);
    check("r2_fault_mask", 64'(bus.fault_mask), 64'b0100);
    drop_ch[2] = 1'b0;

    // Round 3: SPI master busy for 1200 cycles ahead of ch1 forces an overrun
    wait_start(1100, "r3_start", c);
    check("round_period_2", 64'(c - prev0), 64'd1000);
    wait_valid(20, "r3_ch0_result", v);
    bus.spi_busy = 1'b1;
    n = 0;
    repeat (1200) begin
      @(negedge clk);
      if (bus.spi_start === 1'b1) n++;
    end
    bus.spi_busy = 1'b0;
    check("no_start_while_busy", 64'(n), 64'd0);
    repeat (3) wait_valid(200, "r3_result", v);
    check("r3_last_ch", 64'(bus.out_ch), 64'd3);
    check("overrun_set", 64'(bus.overrun), 64'd1);
    wait_start(20, "r4_start", c);
    check("overrun_restart_gap", 64'(c - v), 64'd2);

    // Round 4: scan disabled mid-round, the round still completes
    bus.scan_en = 1'b0;
    repeat (4) wait_valid(200, "r4_result", v);
    n = 0;
    repeat (1100) begin
      @(negedge clk);
      if (bus.spi_start === 1'b1) n++;
    end
    check("no_start_when_disabled", 64'(n), 64'd0);
    check("overrun_sticky", 64'(bus.overrun), 64'd1);

    // Reset during WAIT with a coincident and a late spi_done
    resp_en = 1'b0;
    bus.scan_en = 1'b1;
    wait_start(10, "r5_start", c);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.spi_rx_data = 32'hDEAD_BEEF;
    bus.spi_done = 1'b1;
    @(negedge clk);
    check("reset_mid_wait", outs(), 64'd0);
    bus.spi_done = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    c0 = cyc;
    repeat (5) @(negedge clk);
    bus.spi_done = 1'b1;
    @(negedge clk);
    bus.spi_done = 1'b0;
    wait_start(3100, "restart", c);
    check("restart_cycle", 64'(c - c0), 64'd3000);
    check("pending_results", 64'(exp_q.size()), 64'd0);
    finish_sim();
  end

endmodule
`default_nettype wire
